ones_count_sampler: RTL and testbench

Downstream consumer of the serial ones-counter stage. The block samples the counter's 4-bit running `count` once every `WINDOW` enabled cycles and computes the number of ones seen in that window, modulo 16. Each result is pushed with a sequence number into a small first-word-fall-through FIFO. The bench scoreboard or a host-side reader drains the FIFO through a valid/ready handshake.

---
 rtl/ones_count_sampler.sv | 127 ++++++++++++
 tb/tb_ones_count_sampler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_sampler.sv
`default_nettype none
// ============================================================================
// ones_count_sampler : windowed ones-count deltas queued in a FWFT FIFO
// Revision 1.0
// ============================================================================
module ones_count_sampler #(
  parameter int WINDOW = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [0:3]               count,
  output logic                     delta_valid,
  input  logic                     delta_ready,
  output logic [3:0]               delta,
  output logic [7:0]               seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              WLAST_INT  = WINDOW - 1;
  localparam logic [3:0]      C_WLAST    = WLAST_INT[3:0];
  localparam logic [AW:0]     C_FULL     = DEPTH[AW:0];
  localparam logic [AW:0]     C_LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]   C_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [3:0]    wcnt_q,  wcnt_d;
  logic [3:0]    prev_q,  prev_d;
  logic [7:0]    seq_q,   seq_d;
  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] rptr_q,  rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q,   ovf_d;
  logic [11:0]   mem_q [DEPTH];

  logic [3:0]    w_count;
  logic [3:0]    w_diff;
  logic          w_sample;
  logic          w_pop;
  logic          w_full;
  logic          w_push;

  // count arrives MSB-first as [0:3]; the plain assignment preserves its value
  assign w_count = count;
  assign w_diff  = w_count - prev_q;

  always_comb begin
    wcnt_d   = wcnt_q;
    prev_d   = prev_q;
    seq_d    = seq_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    w_pop    = (level_q != '0) && delta_ready;
    w_full   = (level_q == C_FULL);
    w_sample = en && (wcnt_q == C_WLAST);
    w_push   = w_sample && (!w_full || w_pop);

    if (en) begin
      wcnt_d = w_sample ? 4'd0 : wcnt_q + 4'd1;
    end

    // The sequence number advances even when the entry is dropped
    if (w_sample) begin
      prev_d = w_count;
      seq_d  = seq_q + 8'd1;
      if (!w_push) begin
        ovf_d = 1'b1;
      end
    end

    if (w_push) begin
      wptr_d = wptr_q + C_PTR_ONE;
    end
    if (w_pop) begin
      rptr_d = rptr_q + C_PTR_ONE;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + C_LVL_ONE;
      2'b01:   level_d = level_q - C_LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q  <= 4'd0;
      prev_q  <= 4'd0;
      seq_q   <= 8'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      prev_q  <= prev_d;
      seq_q   <= seq_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is cleared on reset so the head reads {seq 0, delta 0} while empty
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 12'd0;
      end
    end else if (w_push) begin
      mem_q[wptr_q] <= {seq_q, w_diff};
    end
  end

  assign delta_valid  = (level_q != '0);
  assign {seq, delta} = mem_q[rptr_q];
  assign level        = level_q;
  assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ones_count_sampler.sv
`default_nettype none
// ============================================================================
// tb_ones_count_sampler : randomized and directed bench with a queue-based model
// Revision 1.0
// ============================================================================
module tb_ones_count_sampler;

  localparam int WINDOW = 8;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  cnt;
  logic        delta_valid;
  logic        delta_ready;
  logic [3:0]  delta;
  logic [7:0]  seq;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;

  int n_vec;
  int n_bad;
  bit started;

  ones_count_sampler #(.WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .count       (cnt),
    .delta_valid (delta_valid),
    .delta_ready (delta_ready),
    .delta       (delta),
    .seq         (seq),
    .level       (level),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {seq, delta} and a count of enabled cycles
  logic [11:0] mq[$];
  int          m_en_cycles;
  int          m_prev;
  int          m_seq;
  bit          m_ovf;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_en_cycles = 0;
      m_prev      = 0;
      m_seq       = 0;
      m_ovf       = 1'b0;
    end else begin
      bit popped;
      popped = (mq.size() > 0) && delta_ready;
      if (popped) void'(mq.pop_front());
      if (en) begin
        m_en_cycles++;
        if (m_en_cycles == WINDOW) begin
          int d;
          d = (int'(cnt) + 16 - m_prev) % 16;
          m_en_cycles = 0;
          m_prev = int'(cnt);
          if (mq.size() < DEPTH) mq.push_back({8'(m_seq), 4'(d)});
          else                   m_ovf = 1'b1;
          m_seq = (m_seq + 1) % 256;
        end
      end
    end
  end

  // Entries the DUT actually handed over, for the directed literal checks
  logic [11:0] got[$];

  always @(negedge clk) begin
    if (started) begin
      chk("valid", int'(delta_valid), int'(mq.size() != 0));
      chk("level", int'(level), mq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      if (mq.size() != 0) begin
        chk("head_seq", int'(seq), int'(mq[0][11:4]));
        chk("head_delta", int'(delta), int'(mq[0][3:0]));
      end
      if (delta_valid && delta_ready) got.push_back({seq, delta});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_got(input string name, input int idx, input int s, input int d);
    if (got.size() > idx) begin
      chk({name, "_seq"}, int'(got[idx][11:4]), s);
      chk({name, "_delta"}, int'(got[idx][3:0]), d);
    end else begin
      chk({name, "_present"}, got.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'(($urandom_range(0, 1)));
    cnt   = 4'($urandom_range(0, 15));
    ticks(2);
    chk("rst_valid", int'(delta_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_seq", int'(seq), 0);
    reset = 1'b0;
    got.delete();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    started = 1'b0;
    reset = 1'b1;
    en = 1'b0;
    cnt = 4'd0;
    delta_ready = 1'b0;
    tick();
    started = 1'b1;

    // Steady stream: count reads k at the k-th enabled edge after reset
    do_reset();
    en = 1'b1;
    delta_ready = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      cnt = 4'(k);
      tick();
    end
    chk_got("steady0", 0, 0, 8);
    chk_got("steady1", 1, 1, 8);
    chk_got("steady2", 2, 2, 8);

    // Wrap-around: 12, then 3 (delta 7), then a window with no new ones
    do_reset();
    en = 1'b1;
    delta_ready = 1'b1;
    cnt = 4'd12;
    ticks(WINDOW);
    cnt = 4'd3;
    ticks(2 * WINDOW + 2);
    chk_got("wrap0", 0, 0, 12);
    chk_got("wrap1", 1, 1, 7);
    chk_got("wrap2", 2, 2, 0);

    // Overflow: five windows with the consumer stalled
    do_reset();
    en = 1'b1;
    delta_ready = 1'b0;
    for (int k = 1; k <= 5 * WINDOW; k++) begin
      cnt = 4'(k % 16);
      tick();
    end
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    delta_ready = 1'b1;
    ticks(12);
    chk_got("drain0", 0, 0, 8);
    chk_got("drain1", 1, 1, 8);
    chk_got("drain2", 2, 2, 8);
    chk_got("drain3", 3, 3, 8);
    chk_got("drain4", 4, 5, 0);

    // Push and pop together while full
    do_reset();
    en = 1'b1;
    delta_ready = 1'b0;
    cnt = 4'd1;
    ticks(5 * WINDOW - 1);
    delta_ready = 1'b1;
    tick();
    delta_ready = 1'b0;
    chk("full_pp_level", int'(level), 4);
    chk("full_pp_ovf", int'(overflow), 0);
    chk_got("full_pp_pop", 0, 0, 1);

    // Enable gating: five frozen cycles delay the sample by five cycles
    do_reset();
    en = 1'b1;
    delta_ready = 1'b1;
    cnt = 4'd5;
    ticks(4);
    en = 1'b0;
    cnt = 4'd9;
    ticks(5);
    cnt = 4'd5;
    en = 1'b1;
    ticks(3);
    chk("gate_not_yet", int'(delta_valid), 0);
    tick();
    chk("gate_valid", int'(delta_valid), 1);
    chk("gate_delta", int'(delta), 5);
    chk("gate_seq", int'(seq), 0);

    // Mid-run reset with three entries queued
    do_reset();
    en = 1'b1;
    delta_ready = 1'b0;
    cnt = 4'd2;
    ticks(3 * WINDOW);
    chk("mid_level_pre", int'(level), 3);
    reset = 1'b1;
    tick();
    chk("mid_level_post", int'(level), 0);
    reset = 1'b0;
    delta_ready = 1'b1;
    got.delete();
    ticks(WINDOW + 2);
    chk_got("mid_first", 0, 0, 2);

    // Randomized traffic; count behaves like a serial ones counter
    do_reset();
    cnt = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      en          = ($urandom_range(0, 3) != 0);
      delta_ready = 1'($urandom_range(0, 1));
      tick();
      if (reset) cnt = 4'd0;
      else       cnt = cnt + 4'($urandom_range(0, 1));
    end
    reset = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
